// File: rtl/polyshift_seq_pkg.sv
// Shared types for the multi-word shift sequencer.
//   SHIFT_TYPE  : command / shifter operation type
//   seq_state_t : sequencer FSM state
package polyshift_seq_pkg;

  typedef enum logic [1:0] {
    LOGIC = 2'd0,
    ARITH = 2'd1,
    RCR   = 2'd2,
    ROR   = 2'd3
  } SHIFT_TYPE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/polyshift_seq_if.sv
// Command / operand / result streams of polyshift_seq.
//   slave  : the sequencer (accepts cmd and operand words, drives results)
//   master : the requester / consumer side
interface polyshift_seq_if #(
  parameter int WORD_WIDTH = 8,
  parameter int MAX_WORDS  = 16
) ();
  import polyshift_seq_pkg::*;

  logic                            cmd_valid_i;
  logic                            cmd_ready_o;
  SHIFT_TYPE                       cmd_type_i;
  logic [$clog2(WORD_WIDTH)-1:0]   cmd_size_i;
  logic [$clog2(MAX_WORDS+1)-1:0]  cmd_words_i;
  logic [WORD_WIDTH-2:0]           cmd_fill_i;
  logic                            in_valid_i;
  logic                            in_ready_o;
  logic [WORD_WIDTH-1:0]           in_data_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [WORD_WIDTH-1:0]           out_data_o;
  logic                            out_last_o;

  modport slave (
    input  cmd_valid_i, cmd_type_i, cmd_size_i, cmd_words_i, cmd_fill_i,
    input  in_valid_i, in_data_i, out_ready_i,
    output cmd_ready_o, in_ready_o, out_valid_o, out_data_o, out_last_o
  );

  modport master (
    output cmd_valid_i, cmd_type_i, cmd_size_i, cmd_words_i, cmd_fill_i,
    output in_valid_i, in_data_i, out_ready_i,
    input  cmd_ready_o, in_ready_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/polyshift_r.sv
// Single-word right shifter (combinational).
//   type_i : LOGIC zero-fill, ARITH sign-fill, RCR fill from c_i, ROR rotate
//   size_i : shift amount 0..WORD_WIDTH-1
//   d_i    : word to shift
//   c_i    : carry-in bits for RCR; c_i[0] lands just above d_i's MSB
//   q_o    : shifted word
module polyshift_r
  import polyshift_seq_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  SHIFT_TYPE                     type_i,
  input  logic [$clog2(WORD_WIDTH)-1:0] size_i,
  input  logic [WORD_WIDTH-1:0]         d_i,
  input  logic [WORD_WIDTH-2:0]         c_i,
  output logic [WORD_WIDTH-1:0]         q_o
);
  // All modes are one right shift of a {fill, d} double word.
  logic [2*WORD_WIDTH-2:0] w_cat;
  logic [2*WORD_WIDTH-2:0] w_sh;

  always_comb begin
    w_cat = {{(WORD_WIDTH-1){1'b0}}, d_i};
    case (type_i)
      LOGIC:   w_cat = {{(WORD_WIDTH-1){1'b0}}, d_i};
      ARITH:   w_cat = {{(WORD_WIDTH-1){d_i[WORD_WIDTH-1]}}, d_i};
      RCR:     w_cat = {c_i, d_i};
      ROR:     w_cat = {d_i[WORD_WIDTH-2:0], d_i};
      default: w_cat = {{(WORD_WIDTH-1){1'b0}}, d_i};
    endcase
  end

  assign w_sh = w_cat >> size_i;
  assign q_o  = w_sh[WORD_WIDTH-1:0];
endmodule

// File: rtl/polyshift_seq.sv
// Multi-word right-shift sequencer. Streams an N-word operand LS word first
// and emits N shifted words; inner words shift in bits of the next-higher
// word, the top word takes its fill from the command type.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : cmd / operand / result streams (slave side)
//   busy_o        : command in progress
//   done_o        : 1-cycle pulse on command completion
module polyshift_seq
  import polyshift_seq_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int MAX_WORDS  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  polyshift_seq_if.slave      bus,
  output logic                busy_o,
  output logic                done_o
);
  localparam int SW = $clog2(WORD_WIDTH);
  localparam int CW = $clog2(MAX_WORDS+1);

  seq_state_t            r_state;
  SHIFT_TYPE             r_type;
  logic [SW-1:0]         r_size;
  logic [CW-1:0]         r_cnt;     // operand words still to accept
  logic [WORD_WIDTH-2:0] r_fill;
  logic [WORD_WIDTH-1:0] r_hold;    // previous word, waiting for its upper neighbour
  logic [WORD_WIDTH-1:0] r_w0;      // word0, wraps into the top word for ROR
  logic [WORD_WIDTH-1:0] r_out;
  logic                  r_out_vld;
  logic                  r_out_last;
  logic                  r_done;

  logic                  w_cmd_acc, w_in_acc, w_out_free, w_in_rdy;
  SHIFT_TYPE             w_sh_type;
  logic [WORD_WIDTH-2:0] w_sh_c;
  logic [WORD_WIDTH-1:0] w_sh_q;

  // Holding off cmd_ready while done_o is up keeps a new accept out of the
  // completion cycle.
  assign bus.cmd_ready_o = (r_state == IDLE) & ~r_done;
  assign w_cmd_acc       = bus.cmd_valid_i & bus.cmd_ready_o;
  assign w_out_free      = ~r_out_vld | bus.out_ready_i;

  always_comb begin
    w_in_rdy = 1'b0;
    case (r_state)
      FIRST:   w_in_rdy = 1'b1;        // word0 produces no output yet
      STREAM:  w_in_rdy = w_out_free;
      default: w_in_rdy = 1'b0;
    endcase
  end
  assign bus.in_ready_o = w_in_rdy;
  assign w_in_acc       = bus.in_valid_i & w_in_rdy;

  // Inner words: RCR with the incoming word as carry. Top word: per command.
  always_comb begin
    w_sh_type = RCR;
    w_sh_c    = bus.in_data_i[WORD_WIDTH-2:0];
    if (r_state == FLUSH) begin
      case (r_type)
        LOGIC:   w_sh_type = LOGIC;
        ARITH:   w_sh_type = ARITH;
        RCR:     w_sh_c    = r_fill;
        ROR:     w_sh_c    = r_w0[WORD_WIDTH-2:0];
        default: w_sh_type = LOGIC;
      endcase
    end
  end

  polyshift_r #(.WORD_WIDTH(WORD_WIDTH)) u_sh (
    .type_i (w_sh_type),
    .size_i (r_size),
    .d_i    (r_hold),
    .c_i    (w_sh_c),
    .q_o    (w_sh_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_type     <= LOGIC;
      r_size     <= '0;
      r_cnt      <= '0;
      r_fill     <= '0;
      r_hold     <= '0;
      r_w0       <= '0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_out_vld && bus.out_ready_i) r_out_vld <= 1'b0;
      case (r_state)
        IDLE: if (w_cmd_acc) begin
          r_type <= bus.cmd_type_i;
          r_size <= bus.cmd_size_i;
          r_cnt  <= bus.cmd_words_i;
          r_fill <= bus.cmd_fill_i;
          if (bus.cmd_words_i == '0) r_done  <= 1'b1;
          else                       r_state <= FIRST;
        end
        FIRST: if (w_in_acc) begin
          r_hold  <= bus.in_data_i;
          r_w0    <= bus.in_data_i;
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == CW'(1)) ? FLUSH : STREAM;
        end
        STREAM: if (w_in_acc) begin
          r_out      <= w_sh_q;
          r_out_vld  <= 1'b1;
          r_out_last <= 1'b0;
          r_hold     <= bus.in_data_i;
          r_cnt      <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= FLUSH;
        end
        FLUSH: if (w_out_free) begin
          r_out      <= w_sh_q;
          r_out_vld  <= 1'b1;
          r_out_last <= 1'b1;
          r_state    <= DRAIN;
        end
        DRAIN: if (r_out_vld && bus.out_ready_i) begin
          r_out_last <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid_o = r_out_vld;
  assign bus.out_data_o  = r_out;
  assign bus.out_last_o  = r_out_last;
  assign busy_o          = (r_state != IDLE);
  assign done_o          = r_done;
endmodule

// File: tb/tb_polyshift_seq.sv
module tb_polyshift_seq;
  import polyshift_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, done;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  polyshift_seq_if #(.WORD_WIDTH(8), .MAX_WORDS(16)) bus ();

  polyshift_seq #(.WORD_WIDTH(8), .MAX_WORDS(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input SHIFT_TYPE t, input logic [2:0] sz,
                         input int nw, input logic [6:0] fill,
                         input logic [15:0][7:0] din, input logic [15:0][7:0] exp,
                         input bit rnd);
    int ii = 0, oi = 0, dn = 0, cyc = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_type_i  = t;
    bus.cmd_size_i  = sz;
    bus.cmd_words_i = 5'(nw);
    bus.cmd_fill_i  = fill;
    #1 chk({tag, "_cmdrdy"}, bus.cmd_ready_o, 1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    while (!(oi >= nw && dn > 0) && cyc < 400) begin
      bus.out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid_i  = (ii < nw);
      bus.in_data_i   = (ii < nw) ? din[ii] : 8'h00;
      #1;
      if (done) begin
        dn++;
        chk({tag, "_rdy_at_done"}, bus.cmd_ready_o, 0);
      end
      if (bus.in_valid_i && bus.in_ready_o) ii++;
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (oi < nw) begin
          chk($sformatf("%s_data%0d", tag, oi), bus.out_data_o, exp[oi]);
          chk($sformatf("%s_last%0d", tag, oi), bus.out_last_o, (oi == nw-1));
        end else chk({tag, "_extra_out"}, 1, 0);
        oi++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    if (cyc >= 400) chk({tag, "_timeout"}, 1, 0);
    repeat (3) begin
      #1;
      if (done) dn++;
      if (bus.out_valid_o) chk({tag, "_spurious_out"}, 1, 0);
      @(negedge clk);
    end
    chk({tag, "_nwords"}, oi, nw);
    chk({tag, "_ndone"}, dn, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  logic [15:0][7:0] d, e;
  logic [127:0]     big;

  initial begin
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_type_i  = LOGIC;
    bus.cmd_size_i  = '0;
    bus.cmd_words_i = '0;
    bus.cmd_fill_i  = '0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b1;
    #1;
    chk("rst_cmdrdy", bus.cmd_ready_o, 1);
    chk("rst_inrdy",  bus.in_ready_o, 0);
    chk("rst_outvld", bus.out_valid_o, 0);
    chk("rst_outdat", bus.out_data_o, 0);
    chk("rst_last",   bus.out_last_o, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    @(negedge clk); rst_n = 1'b1;

    d = '0; e = '0; d[0] = 8'hA5; d[1] = 8'h3C; e[0] = 8'hCA; e[1] = 8'h03;
    run_cmd("logic", LOGIC, 3'd4, 2, 7'h00, d, e, 1'b0);

    d = '0; e = '0; d[0] = 8'h80; d[1] = 8'hF0; e[0] = 8'h08; e[1] = 8'hFF;
    run_cmd("arith", ARITH, 3'd4, 2, 7'h00, d, e, 1'b0);

    e[0] = 8'h80; e[1] = 8'hF0;
    run_cmd("arith_sz0", ARITH, 3'd0, 2, 7'h00, d, e, 1'b0);

    d = '0; e = '0; d[0] = 8'h01; d[1] = 8'h00; e[0] = 8'h00; e[1] = 8'h80;
    run_cmd("ror2", ROR, 3'd1, 2, 7'h00, d, e, 1'b0);

    d = '0; e = '0; d[0] = 8'h81; e[0] = 8'hC0;
    run_cmd("ror1", ROR, 3'd1, 1, 7'h00, d, e, 1'b0);

    d = '0; e = '0; d[0] = 8'h00; e[0] = 8'hE0;
    run_cmd("rcr1", RCR, 3'd3, 1, 7'h7F, d, e, 1'b0);

    d = '0; e = '0;
    run_cmd("zero", LOGIC, 3'd2, 0, 7'h00, d, e, 1'b0);

    // 16-word LOGIC shift under random backpressure; expected words come
    // from shifting the whole 128-bit operand at once.
    for (int k = 0; k < 16; k++) d[k] = 8'(k * 37 + 8'h5B);
    big = d >> 5;
    e   = big;
    run_cmd("long", LOGIC, 3'd5, 16, 7'h00, d, e, 1'b1);

    // Reset while a result word sits stalled in STREAM.
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_type_i = LOGIC; bus.cmd_size_i = 3'd2;
    bus.cmd_words_i = 5'd4; bus.cmd_fill_i = 7'h00;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.in_data_i = 8'h11;
    @(negedge clk); bus.in_data_i = 8'h22;
    @(negedge clk);
    #1;
    chk("mid_busy",   busy, 1);
    chk("mid_outvld", bus.out_valid_o, 1);
    chk("mid_inrdy",  bus.in_ready_o, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_cmdrdy", bus.cmd_ready_o, 1);
    chk("mrst_inrdy",  bus.in_ready_o, 0);
    chk("mrst_outvld", bus.out_valid_o, 0);
    chk("mrst_outdat", bus.out_data_o, 0);
    chk("mrst_last",   bus.out_last_o, 0);
    chk("mrst_busy",   busy, 0);
    chk("mrst_done",   done, 0);
    @(negedge clk);
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1; rst_n = 1'b1;

    d = '0; e = '0; d[0] = 8'hA5; d[1] = 8'h3C; e[0] = 8'hCA; e[1] = 8'h03;
    run_cmd("post_rst", LOGIC, 3'd4, 2, 7'h00, d, e, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
